// File: rtl/sha256_stream_pad_if.sv
// sha256_stream_pad_if
//   Bundles the message word stream and the digest output of sha256_stream_pad.
//   master : the side that drives message words and consumes the digest
//   slave  : the padder itself
//   Signals: mode, s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready (word stream),
//            m_digest/m_tvalid/m_tready (digest output).
interface sha256_stream_pad_if #(
  parameter int DATA_W = 32
);
  logic                  mode;
  logic [DATA_W-1:0]     s_tdata;
  logic [DATA_W/8-1:0]   s_tkeep;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [255:0]          m_digest;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    output mode, s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_digest, m_tvalid
  );

  modport slave (
    input  mode, s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    output s_tready, m_digest, m_tvalid
  );
endinterface

// File: rtl/sha256_stream_pad.sv
// sha256_stream_pad
//   Byte-granular SHA-256/SHA-224 front end. Buffers an arbitrary-length
//   big-endian byte stream into 512-bit blocks, appends the 0x80 marker,
//   zero fill and 64-bit bit length, runs sha256_core over every block and
//   returns the digest on a valid/ready output.
//   Ports:
//     clk      : clock
//     reset_n  : asynchronous active-low reset (also resets the core)
//     bus      : sha256_stream_pad_if.slave (word stream in, digest out)
//   Build option:
//     SHA256_STREAM_MODE_EN : when defined, bus.mode selects SHA-256 (1) or
//       SHA-224 (0) per message and SHA-224 digests have [31:0] forced to 0.
//       When undefined, mode is ignored and the core always runs SHA-256.

// Iterative SHA-256/224 compression core: one round per cycle, 64 cycles
// per block. ready is low while a block is being compressed; the digest
// register is updated on the same edge that ready rises.
module sha256_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] h_q [8];
  logic [31:0] v_q [8];   // working variables a..h
  logic [31:0] w_q [16];  // sliding message schedule window, w_q[0] = W[t]
  logic        busy_q;
  logic [5:0]  rnd_q;

  logic [31:0] v_nxt [8];
  logic [31:0] w_new;
  logic [31:0] t1, t2;

  always_comb begin
    t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
    t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_nxt[0] = t1 + t2;
    v_nxt[1] = v_q[0];
    v_nxt[2] = v_q[1];
    v_nxt[3] = v_q[2];
    v_nxt[4] = v_q[3] + t1;
    v_nxt[5] = v_q[4];
    v_nxt[6] = v_q[5];
    v_nxt[7] = v_q[6];
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      busy_q <= 1'b0;
      rnd_q  <= '0;
    end else if (!busy_q) begin
      if (init || next) begin
        for (int i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
        for (int i = 0; i < 8; i++) begin
          if (init) begin
            h_q[i] <= mode ? IV256[i] : IV224[i];
            v_q[i] <= mode ? IV256[i] : IV224[i];
          end else begin
            v_q[i] <= h_q[i];
          end
        end
        busy_q <= 1'b1;
        rnd_q  <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) v_q[i] <= v_nxt[i];
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
      rnd_q   <= rnd_q + 6'd1;
      if (rnd_q == 6'd63) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_nxt[i];
        busy_q <= 1'b0;
      end
    end
  end

  assign ready  = ~busy_q;
  assign digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
endmodule

// State table
//   ST_FILL  | accepting message words into the block buffer
//   ST_PAD   | message ended: 0x80 marker, zero fill, length if it fits
//   ST_ISSUE | waiting for the core to go idle, then pulse init/next
//   ST_WAIT  | core compressing the current block
//   ST_EXTRA | length did not fit: build the trailing length-only block
//   ST_OUT   | digest presented, waiting for m_tready
module sha256_stream_pad #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha256_stream_pad_if.slave   bus
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_FILL, ST_PAD, ST_ISSUE, ST_WAIT, ST_EXTRA, ST_OUT
  } state_t;

  state_t       state_q;
  logic [7:0]   blk_q [64];   // blk_q[0] is the first message byte of the block
  logic [6:0]   bp_q;
  logic [63:0]  len_q;
  logic         first_blk_q;
  logic         first_word_q;
  logic         last_blk_q;
  logic         need_len_q;
  logic         marker_q;     // 0x80 already placed in a block of this message
  logic         init_q;
  logic         next_q;
  logic         s_tready_q;
  logic         m_tvalid_q;
  logic [255:0] m_digest_q;

  logic         core_ready;
  logic         core_mode;
  logic [255:0] core_digest;
  logic [511:0] blk_flat;

  logic [3:0]   nlead;
  logic [7:0]   word_b [NB];
  logic         fill_we [64];
  logic [7:0]   fill_byte [64];
  logic [7:0]   len_b [8];
  logic [6:0]   bp_add;

`ifdef SHA256_STREAM_MODE_EN
  logic         mode_q;
  assign core_mode = mode_q;
`else
  logic         unused_mode;
  assign unused_mode = bus.mode;
  assign core_mode   = 1'b1;
`endif

  // Length of the leading run of ones in tkeep; bytes after the first hole
  // are dropped.
  function automatic logic [3:0] lead_ones(input logic [NB-1:0] k);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (run && k[i]) n = n + 4'd1;
      else             run = 1'b0;
    end
    return n;
  endfunction

  always_comb begin
    nlead  = lead_ones(bus.s_tkeep);
    bp_add = bp_q + {3'b000, nlead};
    for (int i = 0; i < NB; i++) word_b[i] = bus.s_tdata[DATA_W-1-8*i -: 8];
    for (int k = 0; k < 8; k++) len_b[k] = len_q[63-8*k -: 8];
    // Route each kept word byte to its block position bp+i.
    for (int j = 0; j < 64; j++) begin
      fill_we[j]   = 1'b0;
      fill_byte[j] = 8'h00;
      for (int i = 0; i < NB; i++) begin
        if (i < int'(nlead) && j == int'(bp_q) + i) begin
          fill_we[j]   = 1'b1;
          fill_byte[j] = word_b[i];
        end
      end
    end
    blk_flat = '0;
    for (int j = 0; j < 64; j++) blk_flat[511-8*j -: 8] = blk_q[j];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FILL;
      for (int j = 0; j < 64; j++) blk_q[j] <= 8'h00;
      bp_q         <= '0;
      len_q        <= '0;
      first_blk_q  <= 1'b1;
      first_word_q <= 1'b1;
      last_blk_q   <= 1'b0;
      need_len_q   <= 1'b0;
      marker_q     <= 1'b0;
      init_q       <= 1'b0;
      next_q       <= 1'b0;
      s_tready_q   <= 1'b1;
      m_tvalid_q   <= 1'b0;
      m_digest_q   <= '0;
`ifdef SHA256_STREAM_MODE_EN
      mode_q       <= 1'b1;
`endif
    end else begin
      init_q <= 1'b0;
      next_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (bus.s_tvalid) begin
            for (int j = 0; j < 64; j++)
              if (fill_we[j]) blk_q[j] <= fill_byte[j];
            bp_q  <= bp_add;
            len_q <= len_q + {57'd0, nlead, 3'b000};
            if (first_word_q) begin
              first_word_q <= 1'b0;
`ifdef SHA256_STREAM_MODE_EN
              mode_q       <= bus.mode;
`endif
            end
            if (bus.s_tlast) begin
              state_q    <= ST_PAD;
              s_tready_q <= 1'b0;
            end else if (bp_add == 7'd64) begin
              state_q    <= ST_ISSUE;
              last_blk_q <= 1'b0;
              need_len_q <= 1'b0;
              s_tready_q <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          for (int j = 0; j < 64; j++) begin
            if (j == int'(bp_q))
              blk_q[j] <= 8'h80;
            else if (j > int'(bp_q))
              blk_q[j] <= (bp_q <= 7'd55 && j >= 56) ? len_b[j % 8] : 8'h00;
          end
          marker_q <= (bp_q < 7'd64);
          if (bp_q <= 7'd55) begin
            last_blk_q <= 1'b1;
            need_len_q <= 1'b0;
          end else begin
            last_blk_q <= 1'b0;
            need_len_q <= 1'b1;
          end
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (core_ready) begin
            if (first_blk_q) init_q <= 1'b1;
            else             next_q <= 1'b1;
            first_blk_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // ready is still high while the core samples init/next; only a
          // ready seen after the pulse marks the end of compression.
          if (!init_q && !next_q && core_ready) begin
            if (last_blk_q) begin
              m_tvalid_q <= 1'b1;
`ifdef SHA256_STREAM_MODE_EN
              m_digest_q <= mode_q ? core_digest : {core_digest[255:32], 32'h0};
`else
              m_digest_q <= core_digest;
`endif
              state_q    <= ST_OUT;
            end else if (need_len_q) begin
              need_len_q <= 1'b0;
              state_q    <= ST_EXTRA;
            end else begin
              bp_q       <= '0;
              s_tready_q <= 1'b1;
              state_q    <= ST_FILL;
            end
          end
        end
        ST_EXTRA: begin
          for (int j = 0; j < 64; j++) begin
            if (j == 0)       blk_q[j] <= marker_q ? 8'h00 : 8'h80;
            else if (j >= 56) blk_q[j] <= len_b[j % 8];
            else              blk_q[j] <= 8'h00;
          end
          last_blk_q <= 1'b1;
          state_q    <= ST_ISSUE;
        end
        ST_OUT: begin
          if (bus.m_tready) begin
            m_tvalid_q   <= 1'b0;
            len_q        <= '0;
            bp_q         <= '0;
            first_blk_q  <= 1'b1;
            first_word_q <= 1'b1;
            last_blk_q   <= 1'b0;
            marker_q     <= 1'b0;
            s_tready_q   <= 1'b1;
            state_q      <= ST_FILL;
          end
        end
        default: begin
          state_q    <= ST_FILL;
          s_tready_q <= 1'b1;
        end
      endcase
    end
  end

  sha256_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (init_q),
    .next    (next_q),
    .mode    (core_mode),
    .block   (blk_flat),
    .ready   (core_ready),
    .digest  (core_digest)
  );

  assign bus.s_tready = s_tready_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_digest = m_digest_q;
endmodule

// File: doc/sha256_stream_pad.md
# sha256_stream_pad

Byte-granular SHA-256/SHA-224 front-end that accepts an arbitrary-length message as a `DATA_W`-bit AXI-Stream-style word stream with byte enables. It performs FIPS 180-4 padding and length insertion in hardware, assembles 512-bit blocks and sequences an internal `sha256_core` through `init`/`next`. It presents the final digest on a valid/ready output. It replaces block-level wrappers that require software-side padding and sits between the packet parser and the response builder.

## Interface
- `DATA_W`, 32, input word width in bits; legal values are 8, 32 and 64 (must divide 512).
- `clk`  input  1  single clock domain.
- `reset_n`  input  1  asynchronous, active-low reset.
- `mode`  input  1  1 = SHA-256, 0 = SHA-224; sampled with the first accepted word of each message.
- `s_tdata`  input  `DATA_W`  message bytes; the byte in the most significant position is first (big-endian).
- `s_tkeep`  input  `DATA_W/8`  byte enables, contiguous from the MSB byte; partial only on the `tlast` word.
- `s_tlast`  input  1  last word of the message.
- `s_tvalid`  input  1  word valid.
- `s_tready`  output  1  word accepted when `s_tvalid & s_tready`.
- `m_digest`  output  256  digest; SHA-224 result in `[255:32]`, `[31:0]` = 0.
- `m_tvalid`  output  1  digest valid; held until taken.
- `m_tready`  input  1  digest consumer ready.

## Operation
- **Buffer:** 512-bit block register with a byte pointer `bp` (0..64). Each accepted word writes its enabled bytes at `bp`, then `bp` advances by the popcount of the leading-ones run of `s_tkeep`. Bytes after the first 0 in `s_tkeep` are dropped.
- **Length counter:** 64-bit bit counter `len`, incremented by 8×bytes per accepted word. Wraps modulo 2^64.
- **States:**
  - **FILL:** `s_tready = 1`.
    - When `bp` reaches 64 on a non-last word → ISSUE, with `last_blk = 0`.
    - When `tlast` is accepted → PAD.
  - **PAD:** one cycle. Writes 0x80 at `bp` (if `bp < 64`) and zero-fills the rest of the block.
    - If `bp ≤ 55` after the 0x80 byte: write `len` into bytes 56..63 and set `last_blk = 1`.
    - Otherwise set `need_len = 1`.
    - Then → ISSUE.
  - **ISSUE:** wait for core `ready`. Pulse `init` for one cycle if this is the message's first block, `next` otherwise. Drive the core `mode` from the latched mode. → WAIT.
  - **WAIT:** wait for core `ready` to rise again.
    - `last_blk` → OUT.
    - `need_len` → EXTRA.
    - Otherwise → FILL, with `bp = 0`.
  - **EXTRA:** build the block. Byte 0 is 0x80 if the 0x80 marker was not yet written (message ended exactly on a block boundary), else 0x00. Bytes 1..55 are 0 and bytes 56..63 carry `len`. Set `last_blk = 1` → ISSUE.
  - **OUT:** `m_tvalid = 1` with the captured core digest, masked for SHA-224. On `m_tready`, clear `len`, `bp` and the first-block flag → FILL.
- A word with `tlast = 1` and `s_tkeep = 0` is a legal zero-length terminator.
- `s_tkeep = 0` on a non-last word is accepted and contributes no bytes.
- `s_tready = 0` in every state except FILL. No new message is accepted before the digest handshake completes.

## Timing
- **Reset values:**
  - State FILL, so `s_tready = 1`.
  - `m_tvalid = 0`, `m_digest = 0`.
  - `bp = 0`, `len = 0`.
  - Core `init`/`next` = 0.
- **Reset mid-message:** the partial message is discarded, the core is reset, and no digest is emitted.
- **Input throughput:** one word per cycle while in FILL.
- **Block cycle:** PAD and EXTRA take 1 cycle each. ISSUE takes ≥1 cycle. WAIT lasts as long as the core's compression latency.
- **Digest output:** `m_tvalid` rises the cycle after the core `ready` rises for the final block. `m_digest` is stable while `m_tvalid & ~m_tready`.
- **Digest accept:** a handshake at cycle N gives `s_tready = 1` at cycle N+1.

## Configuration
- **`SHA256_STREAM_MODE_EN`**
  - Defined: the `mode` port is honoured per message and SHA-224 output masking is implemented.
  - Undefined: the `mode` port is present but ignored, the core `mode` is tied to 1 (SHA-256), and masking logic is removed.

## Test plan
- **"abc":** with `DATA_W = 32`, send one word 0x61626300 with `tkeep = 4'b1110` and `tlast = 1` → `m_digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Empty message:** one word with `tkeep = 0` and `tlast = 1` → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **56-byte message** "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": two core blocks are issued (`need_len` path) → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **SHA-224 "abc":** same stimulus as the first case with `mode = 0` (macro defined) → `m_digest` = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
- **64 × 'a', random `s_tvalid` gaps and `m_tready` held low for 20 cycles:** the EXTRA block begins with 0x80 → ffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb. `m_digest` stays stable while stalled.
- **Mid-message reset:** assert `reset_n = 0` after 30 bytes, then send "abc" → only the "abc" digest appears and `m_tvalid` stays 0 before it.
